// File: rtl/uart_loader_pkg.sv
// Shared FSM encodings and elaboration helpers for the UART frame loader.
package uart_loader_pkg;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_FILL = 2'd1,
    WR_DROP = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  function automatic int word_width(input int bytes_per_word);
    return 8 * bytes_per_word;
  endfunction

endpackage

// File: rtl/frame_bank_ram.sv
// Simple dual-port RAM holding both frame banks; the address MSB selects the bank.
module frame_bank_ram #(
  parameter int ADDR_W = 11,
  parameter int WORD_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [2**ADDR_W];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rdata_q <= '0;
    else         rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_rx_module.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, one-cycle done pulse.
module uart_rx_module
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic       done_o,
  output logic [7:0] byte_o
);

  localparam int CW = (clog2(CLKS_PER_BIT) < 1) ? 1 : clog2(CLKS_PER_BIT);

  rx_state_e   state_q, state_d;
  logic [1:0]  sync_q;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        done_q, done_d;
  logic        rx_s, half_bit, full_bit;

  assign rx_s     = sync_q[1];
  assign half_bit = (clk_cnt_q == CW'((CLKS_PER_BIT - 1) / 2));
  assign full_bit = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= RX_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RX_IDLE:  if (!rx_s) state_d = RX_START;
      RX_START: if (half_bit) state_d = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (full_bit && (bit_idx_q == 3'd7)) state_d = RX_STOP;
      RX_STOP:  if (full_bit) state_d = RX_IDLE;
    endcase
  end

  // The start bit is re-checked at its midpoint so every later sample lands mid-bit.
  always_comb begin
    clk_cnt_d = clk_cnt_q + CW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    done_d    = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        clk_cnt_d = '0;
        bit_idx_d = '0;
      end
      RX_START: if (half_bit) clk_cnt_d = '0;
      RX_DATA: if (full_bit) begin
        clk_cnt_d = '0;
        shift_d   = {rx_s, shift_q[7:1]};
        bit_idx_d = bit_idx_q + 3'd1;
      end
      RX_STOP: if (full_bit) begin
        clk_cnt_d = '0;
        done_d    = rx_s;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q    <= 2'b11;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rx_i};
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      done_q    <= done_d;
    end
  end

  assign done_o = done_q;
  assign byte_o = shift_q;

endmodule

// File: rtl/uart_frame_loader.sv
// Ping-pong frame loader: packs UART bytes into words and fills two frame banks
// so a consumer can read one complete frame while the next one arrives.
module uart_frame_loader
  import uart_loader_pkg::*;
#(
  parameter int FRAME_DEPTH    = 784,
  parameter int BYTES_PER_WORD = 1,
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CLKS_PER_BIT   = 868,
  localparam int WORD_W        = word_width(BYTES_PER_WORD)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_pin_in,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data,
  output logic              frame_valid,
  input  logic              frame_release,
  output logic [1:0]        frames_pending,
  output logic              overrun,
  input  logic              overrun_clear,
  output logic              timeout_abort
);

  localparam int CNT_W = clog2(TIMEOUT_CYCLES + 1);
  localparam int BP_W  = (BYTES_PER_WORD > 1) ? clog2(BYTES_PER_WORD) : 1;

  wr_state_e         state_q, state_d;
  logic [BP_W-1:0]   byte_ptr_q, byte_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              wr_bank_q, wr_bank_d;
  logic              head_bank_q, head_bank_d;
  logic [1:0]        pending_q, pending_d;
  logic              overrun_q, overrun_d;
  logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              we_q, we_d;
  logic [ADDR_W:0]   waddr_q, waddr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              complete_q, complete_d;

  logic              rx_done;
  logic [7:0]        rx_byte;
  logic              bank_free, timed_out, word_end, frame_end, release_ok;
  logic              accept, overrun_set;
  logic [1:0]        pending_eff;
  logic [WORD_W-1:0] lane_word;

  uart_rx_module #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_i (clock),
    .rst_ni(reset),
    .rx_i  (rx_pin_in),
    .done_o(rx_done),
    .byte_o(rx_byte)
  );

  // A frame whose last word is still in flight already owns its bank.
  assign pending_eff = pending_q + 2'(complete_q);
  assign bank_free   = (pending_eff != 2'd2);
  assign timed_out   = (idle_cnt_q == CNT_W'(TIMEOUT_CYCLES));
  assign word_end    = (byte_ptr_q == BP_W'(BYTES_PER_WORD - 1));
  assign frame_end   = word_end && (wr_ptr_q == ADDR_W'(FRAME_DEPTH - 1));
  assign frame_valid = (pending_q != 2'd0);
  assign release_ok  = frame_release && frame_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= WR_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WR_IDLE: begin
        if (rx_done) begin
          if (!bank_free)     state_d = WR_DROP;
          else if (frame_end) state_d = WR_IDLE;
          else                state_d = WR_FILL;
        end
      end
      WR_FILL: begin
        if (rx_done) begin
          if (frame_end) state_d = WR_IDLE;
        end else if (timed_out) begin
          state_d = WR_IDLE;
        end
      end
      WR_DROP: if (!rx_done && timed_out) state_d = WR_IDLE;
      default: state_d = WR_IDLE;
    endcase
  end

  always_comb begin
    accept        = 1'b0;
    overrun_set   = 1'b0;
    timeout_abort = 1'b0;
    unique case (state_q)
      WR_IDLE: begin
        accept      = rx_done && bank_free;
        overrun_set = rx_done && !bank_free;
      end
      WR_FILL: begin
        accept        = rx_done;
        timeout_abort = !rx_done && timed_out;
      end
      default: ;
    endcase
  end

  always_comb begin
    lane_word = word_q;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (byte_ptr_q == BP_W'(i)) lane_word[8*i +: 8] = rx_byte;
    end
  end

  // Writes are registered so a word's last byte reaches the RAM one cycle later.
  always_comb begin
    byte_ptr_d = byte_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    wr_bank_d  = wr_bank_q;
    word_d     = word_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    complete_d = 1'b0;
    if (accept) begin
      word_d = lane_word;
      if (word_end) begin
        we_d       = 1'b1;
        waddr_d    = {wr_bank_q, wr_ptr_q};
        wdata_d    = lane_word;
        byte_ptr_d = '0;
        if (frame_end) begin
          wr_ptr_d   = '0;
          wr_bank_d  = ~wr_bank_q;
          complete_d = 1'b1;
        end else begin
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
      end else begin
        byte_ptr_d = byte_ptr_q + BP_W'(1);
      end
    end
    if (timeout_abort) begin
      byte_ptr_d = '0;
      wr_ptr_d   = '0;
      word_d     = '0;
    end
    idle_cnt_d  = (state_d == WR_IDLE || rx_done) ? '0 : idle_cnt_q + CNT_W'(1);
    pending_d   = pending_q + 2'(complete_q) - 2'(release_ok);
    head_bank_d = head_bank_q ^ release_ok;
    overrun_d   = overrun_set ? 1'b1 : (overrun_clear ? 1'b0 : overrun_q);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      byte_ptr_q  <= '0;
      wr_ptr_q    <= '0;
      wr_bank_q   <= 1'b0;
      head_bank_q <= 1'b0;
      pending_q   <= 2'd0;
      overrun_q   <= 1'b0;
      idle_cnt_q  <= '0;
      word_q      <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      complete_q  <= 1'b0;
    end else begin
      byte_ptr_q  <= byte_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_bank_q   <= wr_bank_d;
      head_bank_q <= head_bank_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      idle_cnt_q  <= idle_cnt_d;
      word_q      <= word_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      complete_q  <= complete_d;
    end
  end

  frame_bank_ram #(
    .ADDR_W(ADDR_W + 1),
    .WORD_W(WORD_W)
  ) u_ram (
    .clk_i  (clock),
    .rst_ni (reset),
    .we_i   (we_q),
    .waddr_i(waddr_q),
    .wdata_i(wdata_q),
    .raddr_i({head_bank_q, rd_addr}),
    .rdata_o(rd_data)
  );

  assign frames_pending = pending_q;
  assign overrun        = overrun_q;

endmodule
